// File: rtl/mem_lane_serializer_pkg.sv
// Shared definitions for the memory lane serializer.
//   mem_ser_state_t  : serializer FSM state encoding
//   WORD_ALIGN_MASK  : clears the byte-offset bits of a byte address; users
//                      slice the low DATA_W bits (DATA_W up to 64)
package mem_lane_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC_A = 2'd1,
        ST_ACC_B = 2'd2,
        ST_DONE  = 2'd3
    } mem_ser_state_t;

    localparam logic [63:0] WORD_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/mem_lane_serializer_if.sv
// Bus bundle between the dual-issue MEM stage, the data memory and the
// serializer.
//   Lane A/B request : MemtoRegMIn*, MemWriteMIn*, ALUOutMIn*, WriteDataMIn*
//   Memory port      : MemReq, MemWe, MemAddr, MemWData (out), MemReady, MemRData (in)
//   Pipeline side    : ReadDataA/B (load results), StallM, MemTimeout
// Modports: slave = serializer view, master = environment (pipeline + memory).
interface mem_lane_serializer_if #(
    parameter int DATA_W = 32
);
    logic              MemtoRegMInA;
    logic              MemWriteMInA;
    logic [DATA_W-1:0] ALUOutMInA;
    logic [DATA_W-1:0] WriteDataMInA;
    logic              MemtoRegMInB;
    logic              MemWriteMInB;
    logic [DATA_W-1:0] ALUOutMInB;
    logic [DATA_W-1:0] WriteDataMInB;

    logic              MemReq;
    logic              MemWe;
    logic [DATA_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic              MemReady;
    logic [DATA_W-1:0] MemRData;

    logic [DATA_W-1:0] ReadDataA;
    logic [DATA_W-1:0] ReadDataB;
    logic              StallM;
    logic              MemTimeout;

    modport slave (
        input  MemtoRegMInA, MemWriteMInA, ALUOutMInA, WriteDataMInA,
        input  MemtoRegMInB, MemWriteMInB, ALUOutMInB, WriteDataMInB,
        input  MemReady, MemRData,
        output MemReq, MemWe, MemAddr, MemWData,
        output ReadDataA, ReadDataB, StallM, MemTimeout
    );

    modport master (
        output MemtoRegMInA, MemWriteMInA, ALUOutMInA, WriteDataMInA,
        output MemtoRegMInB, MemWriteMInB, ALUOutMInB, WriteDataMInB,
        output MemReady, MemRData,
        input  MemReq, MemWe, MemAddr, MemWData,
        input  ReadDataA, ReadDataB, StallM, MemTimeout
    );
endinterface

// File: rtl/mem_lane_serializer_wait_timer.sv
// mem_wait_timer: per-access wait timer.
// Down-counter loaded with MAX_WAIT-1 when an access starts; it counts each
// request cycle and expired_o flags the MAX_WAIT-th request cycle
// (terminal count reached while still running). MAX_WAIT must be >= 1.
//   clk, reset  : clock, synchronous active-high reset
//   load_i      : an access starts next cycle
//   run_i       : a request is being driven this cycle
//   expired_o   : this request cycle is the last one allowed
module mem_wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic run_i,
    output logic expired_o
);
    localparam int unsigned          CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0]     LOAD_VAL = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (run_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/mem_lane_serializer.sv
// mem_lane_serializer: shares one data-memory port between two MEM-stage
// lanes, A (older) then B (younger), stalling the pipeline until both are done.
//   clk      : clock, rising-edge
//   reset    : synchronous active-high reset
//   lane_bus : mem_lane_serializer_if.slave (lane requests, memory port,
//              load results, StallM, sticky MemTimeout)
// Optional build macro MEM_STORE_FWD_EN: a lane-B load from the same word as a
// lane-A store takes A's store data and skips its own memory access.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no access in flight; stall if either lane needs memory
// ST_ACC_A | driving lane A request until MemReady or timeout
// ST_ACC_B | driving lane B request until MemReady or timeout
// ST_DONE  | results held, StallM low so the EX/MEM latch advances
module mem_lane_serializer
    import mem_lane_serializer_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input logic                  clk,
    input logic                  reset,
    mem_lane_serializer_if.slave lane_bus
);
    localparam logic [DATA_W-1:0] ALIGN_MASK = WORD_ALIGN_MASK[DATA_W-1:0];

    mem_ser_state_t    state_q, state_d;
    logic [DATA_W-1:0] rda_q, rda_d;
    logic [DATA_W-1:0] rdb_q, rdb_d;
    logic              timeout_q, timeout_d;

    logic need_a, need_b, store_a, store_b, load_a, load_b;
    logic fwd_hit, go_b, mem_req, act_b;
    logic timer_load, timer_expired, acc_done;
    logic [DATA_W-1:0] addr_a_w, addr_b_w;

    // A lane with both strobes set is a store.
    assign store_a  = lane_bus.MemWriteMInA;
    assign store_b  = lane_bus.MemWriteMInB;
    assign load_a   = lane_bus.MemtoRegMInA & ~lane_bus.MemWriteMInA;
    assign load_b   = lane_bus.MemtoRegMInB & ~lane_bus.MemWriteMInB;
    assign need_a   = lane_bus.MemtoRegMInA | lane_bus.MemWriteMInA;
    assign need_b   = lane_bus.MemtoRegMInB | lane_bus.MemWriteMInB;
    assign addr_a_w = lane_bus.ALUOutMInA & ALIGN_MASK;
    assign addr_b_w = lane_bus.ALUOutMInB & ALIGN_MASK;

`ifdef MEM_STORE_FWD_EN
    assign fwd_hit = store_a & load_b & (addr_a_w == addr_b_w);
`else
    assign fwd_hit = 1'b0;
`endif

    assign go_b     = need_b & ~fwd_hit;
    assign mem_req  = (state_q == ST_ACC_A) || (state_q == ST_ACC_B);
    assign act_b    = (state_q == ST_ACC_B);
    assign acc_done = lane_bus.MemReady | timer_expired;

    // Reload the timer on every entry into an access state, including A -> B.
    assign timer_load = (state_d != state_q) &&
                        ((state_d == ST_ACC_A) || (state_d == ST_ACC_B));

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (timer_load),
        .run_i     (mem_req),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d   = state_q;
        rda_d     = rda_q;
        rdb_d     = rdb_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (need_a) begin
                    state_d = ST_ACC_A;
                end else if (need_b) begin
                    state_d = ST_ACC_B;
                end
            end
            ST_ACC_A: begin
                if (acc_done) begin
                    if (!lane_bus.MemReady) begin
                        timeout_d = 1'b1;
                    end
                    if (load_a) begin
                        rda_d = lane_bus.MemReady ? lane_bus.MemRData : '0;
                    end
                    if (fwd_hit) begin
                        rdb_d = lane_bus.WriteDataMInA;
                    end
                    state_d = go_b ? ST_ACC_B : ST_DONE;
                end
            end
            ST_ACC_B: begin
                if (acc_done) begin
                    if (!lane_bus.MemReady) begin
                        timeout_d = 1'b1;
                    end
                    if (load_b) begin
                        rdb_d = lane_bus.MemReady ? lane_bus.MemRData : '0;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rda_q     <= '0;
            rdb_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rda_q     <= rda_d;
            rdb_q     <= rdb_d;
            timeout_q <= timeout_d;
        end
    end

    assign lane_bus.MemReq     = mem_req;
    assign lane_bus.MemWe      = mem_req & (act_b ? store_b : store_a);
    assign lane_bus.MemAddr    = mem_req ? (act_b ? addr_b_w : addr_a_w) : '0;
    assign lane_bus.MemWData   = mem_req ? (act_b ? lane_bus.WriteDataMInB
                                                  : lane_bus.WriteDataMInA) : '0;
    assign lane_bus.StallM     = ((state_q == ST_IDLE) && (need_a || need_b)) || mem_req;
    assign lane_bus.ReadDataA  = rda_q;
    assign lane_bus.ReadDataB  = rdb_q;
    assign lane_bus.MemTimeout = timeout_q;

endmodule

// File: tb/tb_mem_lane_serializer.sv
// Bench for mem_lane_serializer: table of lane-pair transactions against a
// memory model fed by an expected-request queue, plus hand-written timeout,
// reset-abandon and idle-MemReady sequences.
module tb_mem_lane_serializer;

    localparam int DW = 32;
    localparam int MW = 15;

`ifdef MEM_STORE_FWD_EN
    localparam logic [31:0] V6_RDB   = 32'h0000_CAFE;
    localparam int          V6_STALL = 2;
    localparam int          V6_REQS  = 1;
`else
    localparam logic [31:0] V6_RDB   = 32'h7777_7777;
    localparam int          V6_STALL = 3;
    localparam int          V6_REQS  = 2;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_lane_serializer_if #(.DATA_W(DW)) bus ();

    mem_lane_serializer #(
        .DATA_W   (DW),
        .MAX_WAIT (MW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .lane_bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } req_t;

    typedef struct {
        bit          a_ld, a_st;
        logic [31:0] a_addr, a_wd;
        bit          b_ld, b_st;
        logic [31:0] b_addr, b_wd;
        int          delay;
        logic [31:0] rd_a, rd_b;
        int          exp_stall, exp_reqs;
        logic [31:0] exp_rda, exp_rdb;
    } vec_t;

    req_t        exp_q[$];
    vec_t        vecs[9];
    logic        mem_en = 1'b0;
    int          cur_delay = 0;
    int          wait_cnt = 0;
    int          grants = 0;
    int          req_cycles = 0;
    logic        mdl_ready = 1'b0;
    logic [31:0] mdl_rdata = '0;
    logic        man_ready = 1'b0;
    logic [31:0] man_rdata = '0;
    logic        exp_timeout = 1'b0;

    assign bus.MemReady = mem_en ? mdl_ready : man_ready;
    assign bus.MemRData = mem_en ? mdl_rdata : man_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: grants after cur_delay wait cycles and checks each
    // completed request against the front of the expected queue.
    req_t e;
    always @(negedge clk) begin
        if (!mem_en) begin
            mdl_ready = 1'b0;
            wait_cnt  = 0;
        end else if (bus.MemReq) begin
            req_cycles++;
            if (wait_cnt >= cur_delay) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_req: got addr 0x%08h, want no request", bus.MemAddr);
                    mdl_rdata = '0;
                end else begin
                    e = exp_q.pop_front();
                    chk("req_addr", bus.MemAddr, e.addr);
                    chk("req_we", {31'b0, bus.MemWe}, {31'b0, e.we});
                    chk("req_wdata", bus.MemWData, e.wdata);
                    mdl_rdata = e.rdata;
                end
                mdl_ready = 1'b1;
                grants++;
                wait_cnt = 0;
            end else begin
                mdl_ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            mdl_ready = 1'b0;
            wait_cnt  = 0;
        end
    end

    task automatic drive_lanes(input bit a_ld, input bit a_st, input logic [31:0] a_addr,
                               input logic [31:0] a_wd, input bit b_ld, input bit b_st,
                               input logic [31:0] b_addr, input logic [31:0] b_wd);
        bus.MemtoRegMInA  = a_ld;
        bus.MemWriteMInA  = a_st;
        bus.ALUOutMInA    = a_addr;
        bus.WriteDataMInA = a_wd;
        bus.MemtoRegMInB  = b_ld;
        bus.MemWriteMInB  = b_st;
        bus.ALUOutMInB    = b_addr;
        bus.WriteDataMInB = b_wd;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int  stall = 0;
        int  g0, rc0;
        bit  done = 0;
        bit  fwd = 0;
        @(posedge clk);
        #1;
        mem_en    = 1'b1;
        cur_delay = v.delay;
        drive_lanes(v.a_ld, v.a_st, v.a_addr, v.a_wd, v.b_ld, v.b_st, v.b_addr, v.b_wd);
        if (v.a_ld || v.a_st)
            exp_q.push_back('{v.a_addr & ~32'h3, v.a_st, v.a_wd, v.rd_a});
`ifdef MEM_STORE_FWD_EN
        fwd = v.a_st && v.b_ld && !v.b_st && ((v.a_addr & ~32'h3) == (v.b_addr & ~32'h3));
`endif
        if ((v.b_ld || v.b_st) && !fwd)
            exp_q.push_back('{v.b_addr & ~32'h3, v.b_st, v.b_wd, v.rd_b});
        g0  = grants;
        rc0 = req_cycles;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.StallM) stall++;
            else begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_done: got StallM stuck high, want DONE within 200 cycles", tag);
        end
        chk({tag, "_stall"}, stall, v.exp_stall);
        chk({tag, "_reqs"}, grants - g0, v.exp_reqs);
        chk({tag, "_req_cycles"}, req_cycles - rc0, v.exp_reqs * (v.delay + 1));
        chk({tag, "_rda"}, bus.ReadDataA, v.exp_rda);
        chk({tag, "_rdb"}, bus.ReadDataB, v.exp_rdb);
        chk({tag, "_leftover"}, exp_q.size(), 0);
        chk({tag, "_timeout"}, {31'b0, bus.MemTimeout}, {31'b0, exp_timeout});
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rq, stall;
        bit   early, done;
        vec_t hv;

        //          a_ld a_st a_addr        a_wd          b_ld b_st b_addr        b_wd          dly rd_a          rd_b          stall     reqs     exp_rda       exp_rdb
        vecs[0] = '{1, 0, 32'h0000_0104, 32'h0,         0, 0, 32'h0,         32'h0,         0, 32'hDEAD_BEEF, 32'h0,         2,        1,       32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{0, 1, 32'h0000_0200, 32'h0000_0011, 1, 0, 32'h0000_0300, 32'h0,         0, 32'hFFFF_FFFF, 32'h1234_5678, 3,        2,       32'hDEAD_BEEF, 32'h1234_5678};
        vecs[2] = '{0, 0, 32'h0,         32'h0,         1, 0, 32'h0000_0107, 32'h0,         3, 32'h0,         32'h0BAD_F00D, 5,        1,       32'hDEAD_BEEF, 32'h0BAD_F00D};
        vecs[3] = '{0, 0, 32'h0000_0010, 32'h0,         0, 0, 32'h0000_0020, 32'h0,         0, 32'h0,         32'h0,         0,        0,       32'hDEAD_BEEF, 32'h0BAD_F00D};
        vecs[4] = '{1, 0, 32'h0000_0010, 32'h0,         1, 0, 32'h0000_0023, 32'h0,         1, 32'h1111_2222, 32'h3333_4444, 5,        2,       32'h1111_2222, 32'h3333_4444};
        vecs[5] = '{1, 1, 32'h0000_0008, 32'h0000_0055, 0, 0, 32'h0,         32'h0,         0, 32'hFFFF_FFFF, 32'h0,         2,        1,       32'h1111_2222, 32'h3333_4444};
        vecs[6] = '{0, 1, 32'h0000_0040, 32'h0000_CAFE, 1, 0, 32'h0000_0042, 32'h0,         0, 32'hFFFF_FFFF, 32'h7777_7777, V6_STALL, V6_REQS, 32'h1111_2222, V6_RDB};
        vecs[7] = '{0, 0, 32'h0,         32'h0,         0, 1, 32'h0000_01F3, 32'h0000_ABCD, 2, 32'h0,         32'hFFFF_FFFF, 4,        1,       32'h1111_2222, V6_RDB};
        vecs[8] = '{1, 0, 32'h0000_0000, 32'h0,         0, 1, 32'h0000_0004, 32'h0000_000A, 0, 32'h0000_0009, 32'hFFFF_FFFF, 3,        2,       32'h0000_0009, V6_RDB};

        reset = 1'b1;
        drive_lanes(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_memreq", {31'b0, bus.MemReq}, 32'h0);
        chk("rst_stall", {31'b0, bus.StallM}, 32'h0);
        chk("rst_addr", bus.MemAddr, 32'h0);
        chk("rst_rda", bus.ReadDataA, 32'h0);
        chk("rst_rdb", bus.ReadDataB, 32'h0);
        chk("rst_timeout", {31'b0, bus.MemTimeout}, 32'h0);

        // MemReady with no request in flight must be ignored.
        @(posedge clk);
        #1;
        man_ready = 1'b1;
        man_rdata = 32'h0001_2345;
        repeat (2) @(negedge clk);
        chk("idle_rdy_req", {31'b0, bus.MemReq}, 32'h0);
        chk("idle_rdy_rda", bus.ReadDataA, 32'h0);
        chk("idle_rdy_rdb", bus.ReadDataB, 32'h0);
        @(posedge clk);
        #1;
        man_ready = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Timeout: memory never answers a lane-A load.
        @(posedge clk);
        #1;
        mem_en = 1'b0;
        man_ready = 1'b0;
        drive_lanes(1, 0, 32'h0000_0080, 32'h0, 0, 0, 32'h0, 32'h0);
        rq = 0; stall = 0; early = 0; done = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.MemReq) begin
                rq++;
                if (bus.MemTimeout) early = 1;
            end
            if (bus.StallM) stall++;
            else begin
                done = 1;
                break;
            end
        end
        chk("to_done", {31'b0, done}, 32'h1);
        chk("to_req_cycles", rq, MW);
        chk("to_stall", stall, MW + 1);
        chk("to_early", {31'b0, early}, 32'h0);
        chk("to_flag", {31'b0, bus.MemTimeout}, 32'h1);
        chk("to_rda", bus.ReadDataA, 32'h0);
        exp_timeout = 1'b1;

        // Flag stays set through a normal access afterwards.
        hv = '{1, 0, 32'h0000_0060, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h600D_600D, 32'h0,
               2, 1, 32'h600D_600D, V6_RDB};
        run_vec(hv, "sticky");

        // Reset in the middle of ACC_A abandons the access.
        @(posedge clk);
        #1;
        mem_en = 1'b0;
        man_ready = 1'b0;
        drive_lanes(1, 0, 32'h0000_0084, 32'h0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_memreq", {31'b0, bus.MemReq}, 32'h1);
        chk("mid_addr", bus.MemAddr, 32'h0000_0084);
        @(posedge clk);
        #1;
        reset = 1'b1;
        man_ready = 1'b1;
        man_rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        man_ready = 1'b0;
        @(negedge clk);
        chk("rst_mid_memreq", {31'b0, bus.MemReq}, 32'h0);
        chk("rst_mid_rda", bus.ReadDataA, 32'h0);
        chk("rst_mid_timeout", {31'b0, bus.MemTimeout}, 32'h0);
        chk("rst_mid_stall", {31'b0, bus.StallM}, 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_lanes(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        exp_timeout = 1'b0;
        @(negedge clk);
        chk("post_rst_stall", {31'b0, bus.StallM}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_lane_serializer.md
MEM_LANE_SERIALIZER -- requirements
Module: mem_lane_serializer

Interface
REQ-001 Parameter DATA_W, default 32, data and address width.
REQ-002 Parameter MAX_WAIT, default 15, cycles allowed per memory access before the error flag is raised.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 MemtoRegMInA / MemWriteMInA  in  1 each  lane A load / store request from the EX/MEM latch.
REQ-006 ALUOutMInA / WriteDataMInA  in  DATA_W each  lane A byte address / store data.
REQ-007 MemtoRegMInB / MemWriteMInB / ALUOutMInB / WriteDataMInB  in  same as lane A  lane B (younger instruction).
REQ-008 MemReq / MemWe  out  1 each  data-memory request and write strobe.
REQ-009 MemAddr / MemWData  out  DATA_W each  word-aligned address and store data.
REQ-010 MemReady  in  1  memory completes the current request this cycle; MemRData  in  DATA_W  load data, valid with MemReady.
REQ-011 ReadDataA / ReadDataB  out  DATA_W each  registered load results for the writeback latch.
REQ-012 StallM  out  1  holds the EX/MEM latch and all earlier stages.
REQ-013 MemTimeout  out  1  sticky error flag.

Function
REQ-014 FSM states: IDLE, ACC_A, ACC_B, DONE.
REQ-015 A lane needs memory when its MemtoReg or MemWrite input is 1; if both are 1, the lane is treated as a store.
REQ-016 IDLE: if lane A needs memory, go to ACC_A; else if lane B needs memory, go to ACC_B; else stay in IDLE.
REQ-017 ACC_A: drive lane A's request until MemReady. On MemReady, go to ACC_B if lane B needs memory, else go to DONE.
REQ-018 ACC_B: drive lane B's request until MemReady, then go to DONE.
REQ-019 DONE: always go to IDLE; StallM is 0 so the EX/MEM latch advances at the end of this cycle.
REQ-020 StallM = (IDLE and any lane needs memory) or ACC_A or ACC_B; combinational from state and inputs.
REQ-021 MemReq = 1 only in ACC_A/ACC_B. MemWe = MemReq and the active lane's MemWrite.
REQ-022 MemAddr = active lane address with bits [1:0] forced to 0. MemWData = active lane WriteData. Both are 0 when MemReq = 0.
REQ-023 ReadDataA/B load MemRData on MemReady in ACC_A/ACC_B when that lane is a load; otherwise hold the previous value.
REQ-024 Program order: lane A access always completes before lane B access starts.
REQ-025 Latency with a zero-wait memory (MemReady in the first request cycle): one lane = 2 stall cycles; both lanes = 3 stall cycles.
REQ-026 A per-access wait counter resets on entering ACC_A/ACC_B. If it reaches MAX_WAIT without MemReady, set MemTimeout and treat the access as complete with read data 0.
REQ-027 MemReady while in IDLE or DONE is ignored.

Reset
REQ-028 On reset: state is IDLE; ReadDataA/B, wait counter and MemTimeout are 0. MemReq/MemWe/StallM follow REQ-020..022 from IDLE.
REQ-029 Reset during ACC_A/ACC_B abandons the access; MemReq is 0 in the following cycle and no result is captured.
REQ-030 MemTimeout clears only on reset.

Configuration
REQ-031 Macro MEM_STORE_FWD_EN.
REQ-032 When defined: if lane A is a store and lane B is a load to the same word, ACC_B is skipped and ReadDataB = WriteDataMInA, captured on A's completion.
REQ-033 When not defined: lane B always performs its own memory access.

Structure
REQ-034 A shared package holds the state enum (mem_ser_state_t) and the word-alignment mask constant.
REQ-035 One sub-module, mem_wait_timer: the wait counter and timeout compare, parameterised by MAX_WAIT.

Verification
REQ-036 Load A addr 0x104, zero-wait memory, MemRData 0xDEADBEEF -> MemAddr 0x104; StallM high 2 cycles; ReadDataA = 0xDEADBEEF.
REQ-037 Store A 0x11 to 0x200, load B from 0x300 -> two requests in order (0x200 with MemWe=1, then 0x300 with MemWe=0); StallM high 3 cycles.
REQ-038 Load B addr 0x107, MemReady delayed 3 cycles -> MemAddr 0x104 held for 4 cycles; StallM high 5 cycles.
REQ-039 MEM_STORE_FWD_EN defined; store A 0xCAFE to 0x40, load B from 0x42 -> one memory request only; ReadDataB = 0xCAFE.
REQ-040 MemReady never asserted, MAX_WAIT=15 -> MemTimeout rises after 15 request cycles and FSM reaches DONE; reset asserted mid-ACC_A -> MemReq 0 in the next cycle.
